// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   WORD_ADDR_W   : width of the memory word address (PC[31:2])
//   PC_INCR       : sequential fetch stride in bytes
//   PC_ALIGN_MASK : clears the byte-offset bits of a PC
//   slot_t        : one queue entry (PC+4 of the entry, instruction, filled flag)
package fetch_prefetch_queue_pkg;

  localparam int unsigned WORD_ADDR_W   = 30;
  localparam logic [31:0] PC_INCR       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // The slot stores PC+4 rather than PC: that is the value presented to IF/ID,
  // and a zeroed slot then yields the required out_pcplus4 reset value of 0.
  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] instr;
    logic        filled;
  } slot_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Handshake bundle of the prefetch queue.
//   imem_req_*  : word fetch request toward instruction memory
//   imem_resp_* : in-order instruction return from memory
//   out_*       : queue head toward the IF/ID register (out_ready = IF/ID enable)
//   redirect_*  : taken-branch flush and restart
// master = the prefetch queue, slave = memory / pipeline side.
interface fetch_prefetch_queue_if;
  import fetch_prefetch_queue_pkg::*;

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [WORD_ADDR_W-1:0] imem_req_addr;
  logic                   imem_resp_valid;
  logic [31:0]            imem_resp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [31:0]            out_pcplus4;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pcplus4,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pcplus4,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_prefetch_queue_slot_buf.sv
// DEPTH-entry slot array of the prefetch queue with its alloc/fill/head pointers
// and allocated-slot count.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   alloc, alloc_pc   : reserve slot[alloc] for a fetch issued at alloc_pc
//   fill, fill_instr  : write the next returned instruction into slot[fill]
//   pop               : release the head slot
//   flush             : free every slot and rewind all pointers
//   count             : number of allocated slots
//   head_*            : contents of the head slot
module fetch_slot_buf
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc,
  input  logic [31:0]            alloc_pc,
  input  logic                   fill,
  input  logic [31:0]            fill_instr,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_filled,
  output logic [31:0]            head_instr,
  output logic [31:0]            head_pcplus4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  slot_t          slots [DEPTH];
  logic [PW-1:0]  alloc_ptr;
  logic [PW-1:0]  fill_ptr;
  logic [PW-1:0]  head_ptr;

  // alloc, fill and pop always address different slots: alloc targets a free
  // slot, fill the oldest unfilled one, pop the filled head. The filled bit is
  // cleared on allocation, so a popped slot needs no update.
  always_ff @(posedge clock) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        slots[alloc_ptr].pcplus4 <= alloc_pc + PC_INCR;
        slots[alloc_ptr].filled  <= 1'b0;
        alloc_ptr                <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_ptr].instr  <= fill_instr;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  assign head_filled  = slots[head_ptr].filled;
  assign head_instr   = slots[head_ptr].instr;
  assign head_pcplus4 = slots[head_ptr].pcplus4;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF/ID register.
// Issues in-order word fetches ahead of decode, buffers up to DEPTH tagged
// instructions and flushes everything on a taken-branch redirect.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : memory request/response, IF/ID output and redirect handshakes
//   occupancy    : number of allocated slots (debug)
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_prefetch_queue_if.master bus,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned PDW = $clog2(MAX_OUT + 1);

  logic [31:0]     fetch_pc;
  logic [PDW-1:0]  pending;
  logic [PDW-1:0]  pending_next;
  logic [PDW-1:0]  discard;
  logic [CW-1:0]   count;
  logic            head_filled;
  logic            issue;
  logic            fire;
  logic            drop;
  logic            fill;
  logic            pop;

  assign issue = !reset && !bus.redirect_valid &&
                 (count < CW'(DEPTH)) && (pending < PDW'(MAX_OUT));
  assign fire  = issue && bus.imem_req_ready;
  assign drop  = bus.imem_resp_valid && (discard != '0);
  // A response arriving in the redirect cycle belongs to the old stream.
  assign fill  = bus.imem_resp_valid && !drop && !bus.redirect_valid;
  assign pop   = bus.out_valid && bus.out_ready;

  assign bus.imem_req_valid = issue;
  assign bus.imem_req_addr  = fetch_pc[31:32-WORD_ADDR_W];
  assign bus.out_valid      = (count != '0) && head_filled && !bus.redirect_valid;
  assign occupancy          = count;

  always_comb begin
    pending_next = pending + PDW'(fire) - PDW'(bus.imem_resp_valid);
  end

  // Responses return in order, so after a redirect the first `discard`
  // responses are exactly the stale ones; new requests may issue meanwhile.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pending  <= '0;
      discard  <= '0;
    end else begin
      pending <= pending_next;
      if (bus.redirect_valid) begin
        discard  <= pending_next;
        fetch_pc <= align_pc(bus.redirect_pc);
      end else begin
        if (drop) begin
          discard <= discard - PDW'(1);
        end
        if (fire) begin
          fetch_pc <= fetch_pc + PC_INCR;
        end
      end
    end
  end

  fetch_slot_buf #(
    .DEPTH(DEPTH)
  ) u_slot_buf (
    .clock       (clock),
    .reset       (reset),
    .alloc       (fire),
    .alloc_pc    (fetch_pc),
    .fill        (fill),
    .fill_instr  (bus.imem_resp_data),
    .pop         (pop),
    .flush       (bus.redirect_valid),
    .count       (count),
    .head_filled (head_filled),
    .head_instr  (bus.out_instr),
    .head_pcplus4(bus.out_pcplus4)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] occupancy;

  fetch_prefetch_queue_if bus();

  fetch_prefetch_queue #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .bus      (bus),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Memory model: accepted requests in order, each with the cycle it answers.
  typedef struct {
    logic [29:0] addr;
    int unsigned due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned rdy_pct = 100;
  int unsigned last_due = 0;
  logic [31:0] exp_fetch;   // next address the queue should request
  logic [31:0] exp_pc;      // PC of the next instruction IF/ID should receive
  int          occ;         // slots allocated since last flush/reset
  int          avail;       // instructions returned but not yet consumed
  int          first_acc;
  int          first_out;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
  endtask

  // One clock cycle: check outputs against the transaction-level model, advance
  // the model with this cycle's handshakes, then move to the next cycle.
  task automatic cycle();
    logic        exp_rv, exp_ov, acc, pop;
    int unsigned due;
    logic [31:0] tgt;
    if (rst) bus.imem_resp_valid = 1'b0;
    #1;
    exp_rv = !rst && !bus.redirect_valid && (occ < DEPTH) && (mq.size() < MAX_OUT);
    exp_ov = (avail > 0) && !bus.redirect_valid;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (!rst) begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("occupancy", 32'(occupancy), 32'(occ));
      if (exp_rv) chk("req_addr", 32'(bus.imem_req_addr), 32'(exp_fetch[31:2]));
      if (exp_ov) begin
        chk("out_instr", bus.out_instr, mem_word(exp_pc[31:2]));
        chk("out_pcplus4", bus.out_pcplus4, exp_pc + 32'd4);
      end
    end
    acc = exp_rv && bus.imem_req_ready;
    pop = exp_ov && bus.out_ready;
    if (rst) begin
      mq.delete();
      occ = 0;
      avail = 0;
      exp_fetch = RESET_PC;
      exp_pc = RESET_PC;
      last_due = cyc;
    end else begin
      if (bus.imem_resp_valid && mq.size() > 0) begin
        if (!mq[0].stale && !bus.redirect_valid) avail++;
        void'(mq.pop_front());
      end
      if (bus.redirect_valid) begin
        foreach (mq[i]) mq[i].stale = 1'b1;
        tgt = bus.redirect_pc;
        tgt[1:0] = 2'b00;
        occ = 0;
        avail = 0;
        exp_fetch = tgt;
        exp_pc = tgt;
      end else begin
        if (acc) begin
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          mq.push_back('{addr: exp_fetch[31:2], due: due, stale: 1'b0});
          last_due = due;
          exp_fetch = exp_fetch + 32'd4;
          occ++;
          if (first_acc < 0) first_acc = int'(cyc);
        end
        if (pop) begin
          avail--;
          occ--;
          exp_pc = exp_pc + 32'd4;
          if (first_out < 0) first_out = int'(cyc);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive_mem();
  endtask

  initial begin
    int n;
    logic [31:0] rp;
    rp = RESET_PC;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    exp_fetch = RESET_PC;
    exp_pc    = RESET_PC;
    occ = 0;
    avail = 0;
    first_acc = -1;
    first_out = -1;

    // Reset, then the reset state and first request in the following cycle.
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pcplus4", bus.out_pcplus4, 32'd0);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", 32'(bus.imem_req_addr), 32'(rp[31:2]));

    // 1-cycle memory streaming into an always-ready IF/ID.
    repeat (20) cycle();
    chk("first_out_latency", 32'(first_out - first_acc), 32'd2);

    // Back-pressure: queue fills and issue stops, then drains in order.
    bus.out_ready = 1'b0;
    repeat (10) cycle();
    #1;
    chk("full_occupancy", 32'(occupancy), 32'd4);
    chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.out_ready = 1'b1;
    repeat (10) cycle();

    // 3-cycle memory, steady then with random stalls on both sides.
    lat_min = 3;
    lat_max = 3;
    repeat (30) cycle();
    rdy_pct = 70;
    for (int i = 0; i < 30; i++) begin
      bus.out_ready = ($urandom_range(99) < 70);
      cycle();
    end

    // Redirect to 0x40 with three requests in flight.
    rdy_pct = 100;
    bus.out_ready = 1'b1;
    n = 0;
    while (mq.size() != 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("wait_three_pending", 32'(mq.size()), 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    chk("redir_out_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    bus.redirect_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      cycle();
      n++;
    end
    #1;
    chk("redir_wait_out", 32'(bus.out_valid), 32'd1);
    chk("redir_first_instr", bus.out_instr, mem_word(30'd16));
    chk("redir_first_pcplus4", bus.out_pcplus4, 32'h44);
    repeat (10) cycle();

    // Redirect coinciding with a response and a pop; unaligned target.
    lat_min = 1;
    lat_max = 1;
    n = 0;
    while (!(bus.out_valid && bus.imem_resp_valid) && n < 50) begin
      cycle();
      n++;
    end
    chk("wait_resp_and_pop", 32'(bus.out_valid && bus.imem_resp_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir2_occupancy", 32'(occupancy), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      cycle();
      n++;
    end
    #1;
    chk("redir2_wait_out", 32'(bus.out_valid), 32'd1);
    chk("redir2_first_instr", bus.out_instr, mem_word(30'd16));
    chk("redir2_first_pcplus4", bus.out_pcplus4, 32'h44);
    repeat (10) cycle();

    // Reset mid-stream with two requests pending.
    lat_min = 2;
    lat_max = 2;
    n = 0;
    while (mq.size() != 2 && n < 50) begin
      cycle();
      n++;
    end
    chk("wait_two_pending", 32'(mq.size()), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("midrst_req_addr", 32'(bus.imem_req_addr), 32'(rp[31:2]));
    repeat (10) cycle();

    // Random traffic: variable latency, stalls, redirects and resets.
    lat_min = 1;
    lat_max = 4;
    rdy_pct = 75;
    for (int i = 0; i < 400; i++) begin
      bus.out_ready      = ($urandom_range(99) < 70);
      bus.redirect_valid = ($urandom_range(99) < 4);
      bus.redirect_pc    = $urandom;
      rst                = ($urandom_range(199) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction prefetch queue between the instruction memory and the IF/ID pipeline register.
- Issues in-order word fetches ahead of decode and holds up to DEPTH fetched instructions, each tagged with its PC.
- Presents the queue head with PC+4 to IF/ID through a valid/ready handshake, where ready is the IF/ID enable.
- On a taken branch redirect, flushes all queued and in-flight fetches and restarts at the branch target.

Parameters:
- DEPTH, 4, number of queue slots; power of two, at least 2.
- MAX_OUT, 4, maximum outstanding memory requests, including requests whose responses will be discarded.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  30  word address, equal to fetch_pc[31:2].
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- out_valid  out  1  head slot holds a filled instruction.
- out_ready  in  1  IF/ID consumes the head (IF/ID enable).
- out_instr  out  32  head instruction.
- out_pcplus4  out  32  head slot PC + 4.
- redirect_valid  in  1  taken branch; flush and redirect.
- redirect_pc  in  32  target address; bits [1:0] are ignored and forced to 00.
- occupancy  out  clog2(DEPTH)+1  number of allocated slots (debug).

Behaviour:
- State: fetch_pc; slot array {pc, instr, filled}; pointers alloc/fill/head; alloc_cnt; pending (outstanding requests); discard (responses still to drop).
- Reset, on a clock edge with reset high:
  - fetch_pc = RESET_PC; all pointers, counters and filled bits = 0.
  - Outputs: imem_req_valid=0, out_valid=0, occupancy=0.
  - out_instr and out_pcplus4 reset to 0.
  - Reset mid-operation abandons all state. Late responses from requests made before reset are not discarded; the memory is reset alongside this block.
- Issue:
  - imem_req_valid = !reset && !redirect_valid && alloc_cnt<DEPTH && pending<MAX_OUT.
  - On valid&ready: allocate slot[alloc] with pc=fetch_pc and filled=0; alloc++, alloc_cnt++, pending++, fetch_pc += 4 (modulo 2^32).
- Response, when imem_resp_valid:
  - pending--.
  - If discard>0: discard--, data dropped.
  - Otherwise write instr into slot[fill], set filled=1, fill++.
- Output:
  - out_valid = alloc_cnt>0 && slot[head].filled && !redirect_valid.
  - out_instr and out_pcplus4 come from the head slot, driven combinationally from registers.
  - On out_valid&out_ready: head++, alloc_cnt--.
  - When out_valid=0, out_instr and out_pcplus4 hold their last value; they are don't-care for checking.
- Latency: a request accepted in cycle N with its response in N+1 gives out_valid in N+2. There is no response bypass.
- Full queue: no issue while alloc_cnt==DEPTH. A pop in the same cycle does not enable issue until the next cycle; issue uses the registered alloc_cnt.
- Simultaneous issue, response and pop in one cycle: all three take effect; counter updates combine.
- Redirect cycle:
  - No issue and no pop.
  - All slots freed: alloc_cnt=0, all pointers=0, filled bits cleared.
  - discard_next = pending_next, so every outstanding response, including any arriving in this cycle, is dropped.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - Issue resumes the following cycle. New requests may be issued while discard>0, because responses arrive in order.
- Back-to-back redirects: each redirect recomputes discard from pending; the last redirect_pc wins.
- Counter widths hold 0..DEPTH and 0..MAX_OUT without wrap; slot pointers wrap modulo DEPTH.

Decomposition:
- Shared defines include file fetch_defs.v holds:
  - word-address width (30);
  - PC increment (4);
  - the PC alignment mask.
- Sub-module fetch_slot_buf holds the DEPTH-entry slot array and its three pointers. Its ports: alloc, fill, pop, flush.
- The top level owns fetch_pc, pending, discard and all handshake logic.

Test Plan:
- Reset, RESET_PC=0, 1-cycle memory holding word k at address k, out_ready=1:
  - first imem_req_valid in the cycle after reset deasserts;
  - out_valid 2 cycles after the first accept, with out_instr=mem[0] and out_pcplus4=4;
  - then one instruction per cycle, out_pcplus4 = 8, 12, 16, ...
- out_ready=0 for 10 cycles: occupancy reaches 4 and imem_req_valid drops. Then out_ready=1: 4 instructions are consumed back-to-back in PC order with no loss or duplicate.
- 3-cycle memory latency, MAX_OUT=4: pending never exceeds 4, and the output stream is still in-order and gap-free after warm-up.
- redirect_valid with redirect_pc=32'h40 while 3 requests are pending:
  - the next 3 responses are dropped;
  - the first out_instr=mem[16], with out_pcplus4=32'h44;
  - out_valid=0 in the redirect cycle.
- Redirect in the same cycle as a response and a pop: the response is dropped, the pop is ignored, and occupancy=0 in the next cycle. Redirect to 32'h43 fetches word 16.
- Reset asserted mid-stream with 2 pending: the next cycle shows occupancy=0, out_valid=0, and fetch restarts at RESET_PC.
